msg_rom_streamer: RTL and testbench

Parametrised message source that streams a fixed character table (default ASCII "ENGINEERING") one character per accepted transfer over a valid/ready interface. Replaces the bare combinational character lookup with a sequenced, back-pressurable, loopable stream. It feeds display/UART-style consumers in the same design. The table lookup is a separate combinational sub-module; this block owns sequencing, handshake and status.

---
 rtl/msg_pkg.sv | 21 ++
 rtl/msg_table.sv | 15 +
 rtl/msg_rom_streamer.sv | 86 ++++++++
 tb/tb_msg_rom_streamer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// msg_pkg: shared character constants, state encoding and message lookup
package msg_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int MSG_LEN_DEF = 11;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_N = 8'h4E;
  localparam logic [7:0] CH_G = 8'h47;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_R = 8'h52;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic logic [7:0] msg_char(input int i);
    case (i)
      0, 5, 6: return CH_E;
      1, 4, 9: return CH_N;
      2, 10:   return CH_G;
      3, 8:    return CH_I;
      7:       return CH_R;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/msg_table.sv
// msg_table: combinational index to character lookup, zero past the message
module msg_table
  import msg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int MSG_LEN = MSG_LEN_DEF
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data
);
  // entries at or beyond the message length read as zero
  always_comb data = (int'(idx) < MSG_LEN && int'(idx) < DEPTH) ? DATA_W'(msg_char(int'(idx))) : '0;
endmodule

// File: rtl/msg_rom_streamer.sv
// msg_rom_streamer: streams the character table over valid/ready with loop and abort
module msg_rom_streamer
  import msg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              loop_en,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  msg_count
);
  if (MSG_LEN < 1 || MSG_LEN > DEPTH) begin : g_bad_len
    $error("msg_rom_streamer: MSG_LEN must be within 1..DEPTH");
  end
  state_t state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [DATA_W-1:0] tbl_data, data_n;
  logic [CNT_W-1:0] cnt_n;
  logic valid_n, done_n, xfer, at_last;
  assign xfer = out_valid & out_ready;
  assign at_last = int'(idx) == MSG_LEN - 1;
  assign out_last = out_valid & at_last;
  assign busy = state == STREAM;
  // the table is addressed by the next index so out_data can be registered
  msg_table #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MSG_LEN(MSG_LEN)) u_table (
    .idx(idx_n),
    .data(tbl_data)
  );
  assign data_n = valid_n ? tbl_data : '0;
  // next state: abort beats everything, start only from idle, advance on transfer
  always_comb begin
    state_n = state;
    idx_n = idx;
    valid_n = out_valid;
    done_n = 1'b0;
    cnt_n = msg_count;
    if (abort) begin
      state_n = IDLE;
      idx_n = '0;
      valid_n = 1'b0;
    end else if (state == IDLE && start) begin
      state_n = STREAM;
      idx_n = '0;
      valid_n = 1'b1;
    end else if (state == STREAM && xfer) begin
      if (!at_last) idx_n = idx + 1'b1;
      else begin
        cnt_n = msg_count + 1'b1;
        idx_n = '0;
        valid_n = loop_en;
        done_n = !loop_en;
        state_n = loop_en ? STREAM : IDLE;
      end
    end
  end
  // registered state and outputs, asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      done <= 1'b0;
      msg_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      out_valid <= valid_n;
      out_data <= data_n;
      done <= done_n;
      msg_count <= cnt_n;
    end
  end
endmodule

// File: tb/tb_msg_rom_streamer.sv
// tb_msg_rom_streamer: directed and random stimulus against a transfer-level model
module tb_msg_rom_streamer;
  logic clk = 1'b0;
  logic rst_n, start, loop_en, abort, ready;
  logic valid, last, busy, done;
  logic [7:0] data, cnt;
  logic b_start, b_loop, b_abort, b_ready;
  logic b_valid, b_last, b_busy, b_done;
  logic [7:0] b_data, b_cnt;
  int total = 0, bad = 0;
  logic [7:0] msg [11] = '{8'h45, 8'h4E, 8'h47, 8'h49, 8'h4E, 8'h45, 8'h45, 8'h52, 8'h49, 8'h4E, 8'h47};
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int pos, xfers = 0, dones = 0;
  logic [7:0] exp_cnt, pd;
  logic exp_done, exp_valid, pv, pr, pab, pl;

  always #5 clk = ~clk;

  msg_rom_streamer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop_en(loop_en), .abort(abort),
    .out_ready(ready), .out_valid(valid), .out_data(data), .out_last(last),
    .busy(busy), .done(done), .msg_count(cnt)
  );

  msg_rom_streamer #(.MSG_LEN(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(b_start), .loop_en(b_loop), .abort(b_abort),
    .out_ready(b_ready), .out_valid(b_valid), .out_data(b_data), .out_last(b_last),
    .busy(b_busy), .done(b_done), .msg_count(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // message-level model: position within the message, active flag, completed count
  task automatic monitor();
    if (!rst_n) begin
      pos = 0; exp_cnt = 0; exp_done = 0; exp_valid = 0; pv = 0; pr = 0; pab = 0; pd = 0; pl = 0;
    end else begin
      chk("count", cnt, exp_cnt);
      chk("done", done, exp_done);
      chk("valid", valid, exp_valid);
      chk("busy", busy, exp_valid);
      if (!valid) chk("idle_data", data, 0);
      if (pv && !pr && !pab) chk("hold", {data, last}, {pd, pl});
      if (valid && ready) begin
        chk("data", data, msg[pos]);
        chk("last", last, pos == 10);
        xfers++;
      end
      exp_done = 0;
      if (abort) begin
        exp_valid = 0; pos = 0;
      end else if (!exp_valid) begin
        if (start) begin exp_valid = 1; pos = 0; end
      end else if (valid && ready) begin
        if (pos == 10) begin
          exp_cnt++;
          pos = 0;
          if (!loop_en) begin exp_valid = 0; exp_done = 1; dones++; end
        end else pos++;
      end
      pv = valid; pr = ready; pab = abort; pd = data; pl = last;
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
  end

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic run_until_done(input int mode, input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      ready = mode == 0 ? 1'b1 : mode == 1 ? pat[i % 4] : ($urandom_range(0, 3) != 0);
      tick();
      i++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int x0, d0, i;
    rst_n = 0; start = 0; loop_en = 0; abort = 0; ready = 0;
    b_start = 0; b_loop = 0; b_abort = 0; b_ready = 0;
    repeat (2) tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cnt, 0);
    rst_n = 1;
    tick();
    // single message with ready held high
    ready = 1;
    x0 = xfers;
    pulse_start();
    chk("s1_latency", {valid, data}, {1'b1, 8'h45});
    run_until_done(0, 20);
    chk("s1_xfers", xfers - x0, 11);
    chk("s1_cnt", cnt, 1);
    tick();
    chk("s1_busy", busy, 0);
    // stalls with a 1-0-0-1 ready pattern
    x0 = xfers;
    pulse_start();
    run_until_done(1, 60);
    chk("s2_xfers", xfers - x0, 11);
    chk("s2_cnt", cnt, 2);
    // three looped messages
    x0 = xfers; d0 = dones;
    ready = 1; loop_en = 1;
    pulse_start();
    i = 0;
    while (xfers - x0 < 33 && i < 100) begin
      loop_en = (xfers - x0 < 32);
      tick();
      i++;
    end
    chk("s3_xfers", xfers - x0, 33);
    chk("s3_done", done, 1);
    chk("s3_dones", dones - d0, 1);
    chk("s3_cnt", cnt, 5);
    loop_en = 0;
    // abort after the fourth character
    x0 = xfers;
    pulse_start();
    i = 0;
    while (xfers - x0 < 4 && i < 20) begin tick(); i++; end
    chk("s4_four", xfers - x0, 4);
    ready = 0; abort = 1;
    tick();
    abort = 0;
    chk("s4_valid", valid, 0);
    chk("s4_done", done, 0);
    chk("s4_cnt", cnt, 5);
    tick();
    chk("s4_done2", done, 0);
    ready = 1;
    pulse_start();
    chk("s4_restart", data, 8'h45);
    run_until_done(0, 20);
    chk("s4_cnt2", cnt, 6);
    // random stimulus
    for (int k = 0; k < 800; k++) begin
      ready = $urandom_range(0, 9) < 7;
      start = $urandom_range(0, 15) == 0;
      loop_en = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 59) == 0;
      tick();
    end
    start = 0; abort = 0; loop_en = 0; ready = 1;
    i = 0;
    while (valid && i < 50) begin tick(); i++; end
    chk("drain", valid, 0);
    // asynchronous reset mid-stream
    loop_en = 1;
    pulse_start();
    repeat (3) tick();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", cnt, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    loop_en = 0;
    tick();
    chk("arst_noresume", valid, 0);
    start = 1; abort = 1;
    tick();
    chk("sa_valid", valid, 0);
    start = 0; abort = 0;
    tick();
    chk("sa_valid2", valid, 0);
    // single-character message instance
    b_ready = 1;
    b_start = 1;
    tick();
    b_start = 0;
    chk("one_first", {b_valid, b_data, b_last}, {1'b1, 8'h45, 1'b1});
    tick();
    chk("one_done", {b_valid, b_done}, {1'b0, 1'b1});
    chk("one_cnt", b_cnt, 1);
    tick();
    chk("one_done_pulse", b_done, 0);
    b_loop = 1;
    b_start = 1;
    tick();
    b_start = 0;
    for (int k = 0; k < 254; k++) begin
      chk("one_loop", {b_valid, b_data, b_last, b_done}, {1'b1, 8'h45, 1'b1, 1'b0});
      tick();
    end
    b_loop = 0;
    tick();
    chk("one_wrap_cnt", b_cnt, 0);
    chk("one_wrap_done", {b_valid, b_done}, {1'b0, 1'b1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
